rr_select_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 4-way, active-low select resource among 4 requesters.

---
 rtl/rr_select_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_select_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter for one shared 4-way active-low select: bounded grant length,
// dead cycles between grants, registered index/enable and decoded one-hot outputs.
module rr_select_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_e_n,
  output logic [3:0] sel_n,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [3:0] GAP_LOAD  = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       sel_e_n_q, sel_e_n_d;
  logic [3:0] sel_n_q, sel_n_d;
  logic       timeout_q, timeout_d;

  logic [1:0] arb_ptr;
  logic [1:0] arb_idx;
  logic       release_now;
  logic       do_arb;

  function automatic logic [3:0] decode_n(input logic [1:0] idx);
    logic [3:0] res;
    case (idx)
      2'd0:    res = 4'b0111;
      2'd1:    res = 4'b1011;
      2'd2:    res = 4'b1101;
      default: res = 4'b1110;
    endcase
    return res;
  endfunction

  // A zero-gap release re-arbitrates at the same edge, so it must already see the advanced pointer.
  always_comb begin
    arb_ptr = (state_q == GRANT) ? idx_q + 2'd1 : rr_ptr_q;
    arb_idx = arb_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[arb_ptr + 2'(i)]) arb_idx = arb_ptr + 2'(i);
    end
  end

  assign release_now = !req[idx_q] || (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sel_e_n_d  = sel_e_n_q;
    sel_n_d    = sel_n_q;
    timeout_d  = 1'b0;
    do_arb     = 1'b0;

    case (state_q)
      IDLE: do_arb = 1'b1;
      GRANT: begin
        if (release_now) begin
          rr_ptr_d  = idx_q + 2'd1;
          timeout_d = req[idx_q];
          if (IDLE_GAP > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
            sel_e_n_d = 1'b1;
            sel_n_d   = 4'b1111;
          end else begin
            do_arb = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) do_arb = 1'b1;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (do_arb) begin
      if (|req) begin
        state_d    = GRANT;
        idx_d      = arb_idx;
        hold_cnt_d = 8'd0;
        sel_e_n_d  = 1'b0;
        sel_n_d    = decode_n(arb_idx);
      end else begin
        state_d   = IDLE;
        sel_e_n_d = 1'b1;
        sel_n_d   = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      idx_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 4'd0;
      sel_e_n_q  <= 1'b1;
      sel_n_q    <= 4'b1111;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sel_e_n_q  <= sel_e_n_d;
      sel_n_q    <= sel_n_d;
      timeout_q  <= timeout_d;
    end
  end

  assign sel_a   = idx_q[1];
  assign sel_b   = idx_q[0];
  assign sel_e_n = sel_e_n_q;
  assign sel_n   = sel_n_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed and random checks of rr_select_arbiter: a default-parameter instance and a
// HOLD_MAX=4 / IDLE_GAP=0 instance share clock and reset but have separate requests.
module tb_rr_select_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] req2 = 4'b0000;

   logic       sel_a, sel_b, sel_e_n, timeout;
   logic [3:0] sel_n;
   logic       sel_a2, sel_b2, sel_e_n2, timeout2;
   logic [3:0] sel_n2;

   int checks = 0;
   int errors = 0;

   // Expected active-low one-hot per index, written out by hand.
   logic [3:0] dec_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Observed vectors are {sel_e_n, sel_n, sel_a, sel_b, timeout}.
   logic [7:0] obs1, obs2;
   assign obs1 = {sel_e_n, sel_n, sel_a, sel_b, timeout};
   assign obs2 = {sel_e_n2, sel_n2, sel_a2, sel_b2, timeout2};

   rr_select_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .sel_a(sel_a), .sel_b(sel_b), .sel_e_n(sel_e_n), .sel_n(sel_n), .timeout(timeout)
   );

   rr_select_arbiter #(.HOLD_MAX(4), .IDLE_GAP(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req2),
      .sel_a(sel_a2), .sel_b(sel_b2), .sel_e_n(sel_e_n2), .sel_n(sel_n2), .timeout(timeout2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] exp;
      req = 4'b1111;
      rst_n = 1'b0;
      exp = {1'b1, 4'b1111, 2'b00, 1'b0};
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL reset_cycle%0d: got %b expected %b", c, obs1, exp);
         end
         checks++;
         if (obs2 !== exp) begin
            errors++;
            $display("[TB] FAIL reset2_cycle%0d: got %b expected %b", c, obs2, exp);
         end
      end
      rst_n = 1'b1;
      tick();
      exp = {1'b0, 4'b0111, 2'b00, 1'b0};
      checks++;
      if (obs1 !== exp) begin
         errors++;
         $display("[TB] FAIL reset_first_grant: got %b expected %b", obs1, exp);
      end
   endtask

   task automatic test_single_grant();
      logic [7:0] exp;
      req = 4'b0000;
      do_reset(2);
      req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         tick();
         exp = {1'b0, 4'b1101, 2'b10, 1'b0};
         checks++;
         if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL single_grant_cycle%0d: got %b expected %b", c, obs1, exp);
         end
      end
      req = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         exp = {1'b1, 4'b1111, 2'b10, 1'b0};
         checks++;
         if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL single_release_cycle%0d: got %b expected %b", c, obs1, exp);
         end
      end
   endtask

   task automatic test_rotation();
      logic [7:0] exp;
      logic [1:0] idx;
      req = 4'b1111;
      do_reset(2);
      for (int g = 0; g < 5; g++) begin
         idx = 2'(g % 4);
         for (int c = 0; c < 8; c++) begin
            tick();
            exp = {1'b0, dec_tab[idx], idx, 1'b0};
            checks++;
            if (obs1 !== exp) begin
               errors++;
               $display("[TB] FAIL rotation_g%0d_c%0d: got %b expected %b", g, c, obs1, exp);
            end
         end
         tick();
         exp = {1'b1, 4'b1111, idx, 1'b1};
         checks++;
         if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL rotation_gap%0d: got %b expected %b", g, obs1, exp);
         end
      end
      req = 4'b0000;
   endtask

   task automatic test_no_gap();
      logic [7:0] exp;
      req2 = 4'b0001;
      do_reset(2);
      for (int e = 1; e <= 13; e++) begin
         tick();
         exp = {1'b0, 4'b0111, 2'b00, (e > 1 && e % 4 == 1)};
         checks++;
         if (obs2 !== exp) begin
            errors++;
            $display("[TB] FAIL no_gap_edge%0d: got %b expected %b", e, obs2, exp);
         end
      end
      req2 = 4'b0000;
   endtask

   task automatic test_reset_mid_grant();
      logic [7:0] exp;
      req = 4'b1111;
      do_reset(1);
      repeat (21) tick();
      exp = {1'b0, 4'b1101, 2'b10, 1'b0};
      checks++;
      if (obs1 !== exp) begin
         errors++;
         $display("[TB] FAIL mid_grant_before: got %b expected %b", obs1, exp);
      end
      rst_n = 1'b0;
      tick();
      exp = {1'b1, 4'b1111, 2'b00, 1'b0};
      checks++;
      if (obs1 !== exp) begin
         errors++;
         $display("[TB] FAIL mid_grant_reset: got %b expected %b", obs1, exp);
      end
      rst_n = 1'b1;
      tick();
      exp = {1'b0, 4'b0111, 2'b00, 1'b0};
      checks++;
      if (obs1 !== exp) begin
         errors++;
         $display("[TB] FAIL mid_grant_restart: got %b expected %b", obs1, exp);
      end
      req = 4'b0000;
   endtask

   task automatic test_random();
      int         run = 0;
      int         gap = 0;
      int         max_wait;
      int         wait_cnt [4] = '{0, 0, 0, 0};
      logic       seen = 1'b0;
      logic [1:0] prev_idx = 2'b00;
      logic [1:0] idx;
      logic [3:0] exp_n;
      req = 4'b0000;
      req2 = 4'b0000;
      do_reset(2);
      for (int n = 0; n < 10000; n++) begin
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(7) == 0) req[k] = ~req[k];
            if ($urandom_range(7) == 0) req2[k] = ~req2[k];
         end
         tick();
         idx = {sel_a, sel_b};
         exp_n = sel_e_n ? 4'b1111 : dec_tab[idx];
         checks++;
         if (sel_n !== exp_n) begin
            errors++;
            $display("[TB] FAIL decode_cycle%0d: got %b expected %b", n, sel_n, exp_n);
         end
         exp_n = sel_e_n2 ? 4'b1111 : dec_tab[{sel_a2, sel_b2}];
         checks++;
         if (sel_n2 !== exp_n) begin
            errors++;
            $display("[TB] FAIL decode2_cycle%0d: got %b expected %b", n, sel_n2, exp_n);
         end
         if (!sel_e_n) begin
            if (run > 0 && idx != prev_idx) begin
               checks++;
               if (run > 8) begin
                  errors++;
                  $display("[TB] FAIL grant_length_cycle%0d: got %0d expected at most 8", n, run);
               end
               run = 0;
               gap = 0;
            end
            if (run == 0) begin
               if (seen) begin
                  checks++;
                  if (gap < 1) begin
                     errors++;
                     $display("[TB] FAIL dead_gap_cycle%0d: got %0d expected at least 1", n, gap);
                  end
               end
               seen = 1'b1;
            end
            run++;
            prev_idx = idx;
            gap = 0;
         end else begin
            if (run > 0) begin
               checks++;
               if (run > 8) begin
                  errors++;
                  $display("[TB] FAIL grant_length_cycle%0d: got %0d expected at most 8", n, run);
               end
            end
            run = 0;
            gap++;
         end
         max_wait = 0;
         for (int k = 0; k < 4; k++) begin
            if (req[k] && !(!sel_e_n && idx == 2'(k))) wait_cnt[k]++;
            else                                       wait_cnt[k] = 0;
            if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
         end
         checks++;
         if (max_wait > 28) begin
            errors++;
            $display("[TB] FAIL starvation_cycle%0d: got wait %0d expected at most 28", n, max_wait);
         end
      end
      req = 4'b0000;
      req2 = 4'b0000;
   endtask

   initial begin
      $display("[TB] starting rr_select_arbiter bench");
      test_reset();
      test_single_grant();
      test_rotation();
      test_no_gap();
      test_reset_mid_grant();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
